// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA key-generation datapath blocks.
package rsa_pkg;

    // Extended-GCD controller states
    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIVIDE,
        UPDATE,
        DONE
    } egcd_state_t;

endpackage

// File: rtl/udiv_seq.sv
// Sequential restoring unsigned divider, one quotient bit per cycle.
// The start edge loads the operands and performs the first bit step, so
// valid rises WORD_WIDTH cycles after start was sampled and then holds
// until the next start. Requires WORD_WIDTH >= 2.
module udiv_seq #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] dividend,
    input  logic [WORD_WIDTH-1:0] divisor,
    output logic [WORD_WIDTH-1:0] quotient,
    output logic [WORD_WIDTH-1:0] remainder,
    output logic                  valid
);

    localparam int CW = $clog2(WORD_WIDTH + 1);

    logic [WORD_WIDTH-1:0] quo_q, rem_q, dvs_q;
    logic [CW-1:0]         cnt_q;
    logic                  valid_q;

    logic [WORD_WIDTH-1:0] quo_in, rem_in, dvs_in;
    logic [WORD_WIDTH:0]   trial;
    logic                  ge;
    logic [WORD_WIDTH-1:0] quo_nxt, rem_nxt;

    // One restoring step: shift next dividend bit into the partial remainder,
    // subtract the divisor when it fits. A fresh start steps from the inputs.
    always_comb begin
        quo_in  = start ? dividend : quo_q;
        rem_in  = start ? '0       : rem_q;
        dvs_in  = start ? divisor  : dvs_q;
        trial   = {rem_in, quo_in[WORD_WIDTH-1]};
        ge      = (trial >= {1'b0, dvs_in});
        // When ge, trial - divisor < divisor, so the low word is exact
        rem_nxt = ge ? (trial[WORD_WIDTH-1:0] - dvs_in) : trial[WORD_WIDTH-1:0];
        quo_nxt = {quo_in[WORD_WIDTH-2:0], ge};
    end

    // Operand/partial registers and step counter
    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (start) begin
            quo_q   <= quo_nxt;
            rem_q   <= rem_nxt;
            dvs_q   <= divisor;
            cnt_q   <= CW'(WORD_WIDTH - 1);
            valid_q <= 1'b0;
        end else if (cnt_q != '0) begin
            quo_q <= quo_nxt;
            rem_q <= rem_nxt;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1))
                valid_q <= 1'b1;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign valid     = valid_q;

endmodule

// File: rtl/extended_gcd.sv
// Iterative extended Euclid: gcd(a,n) and the Bezout coefficient t with
// t*a == gcd (mod n). One loop iteration costs CHECK + WORD_WIDTH DIVIDE
// cycles + UPDATE; the divide is done by the sequential udiv_seq.
module extended_gcd
    import rsa_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [WORD_WIDTH-1:0]        a,
    input  logic [WORD_WIDTH-1:0]        n,
    output logic                         ready,
    output logic                         busy,
    output logic                         done,
    output logic [WORD_WIDTH-1:0]        gcd_result,
    output logic signed [WORD_WIDTH:0]   coeff_i
);

    egcd_state_t state_q, state_d;

    logic [WORD_WIDTH-1:0]        r0_q, r1_q;
    logic signed [WORD_WIDTH:0]   t0_q, t1_q;
    logic                         div_start, div_valid;
    logic [WORD_WIDTH-1:0]        div_quo, div_rem;
    logic signed [WORD_WIDTH:0]   qt1, t_next;

    udiv_seq #(.WORD_WIDTH(WORD_WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (r0_q),
        .divisor   (r1_q),
        .quotient  (div_quo),
        .remainder (div_rem),
        .valid     (div_valid)
    );

    // t0 - q*t1 is truncated to WORD_WIDTH+1 bits and is exact there, so only
    // the low WORD_WIDTH+1 bits of the signed product are ever needed; a
    // product formed at that width carries exactly those bits.
    assign qt1    = $signed({1'b0, div_quo}) * t1_q;
    assign t_next = t0_q - qt1;

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic and divider launch
    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        case (state_q)
            IDLE:   if (start) state_d = CHECK;
            CHECK: begin
                // Divider is only launched with a nonzero divisor
                if (r1_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d   = DIVIDE;
                    div_start = 1'b1;
                end
            end
            DIVIDE: if (div_valid) state_d = UPDATE;
            UPDATE: state_d = CHECK;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Euclid registers and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r0_q       <= '0;
            r1_q       <= '0;
            t0_q       <= '0;
            t1_q       <= '0;
            gcd_result <= '0;
            coeff_i    <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    r0_q <= n;
                    r1_q <= a;
                    t0_q <= '0;
                    t1_q <= (WORD_WIDTH + 1)'(1);
                end
                CHECK: if (r1_q == '0) begin
                    gcd_result <= r0_q;
                    coeff_i    <= t0_q;
                end
                UPDATE: begin
                    r0_q <= r1_q;
                    r1_q <= div_rem;
                    t0_q <= t1_q;
                    t1_q <= t_next;
                end
                default: ;
            endcase
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_extended_gcd.sv
// Scoreboard bench for extended_gcd: stimulus pushes expected results and
// done cycle; a negedge monitor pops and compares on every done pulse.
module tb_extended_gcd;

    localparam int W = 32;

    logic                clk = 1'b0;
    logic                rst, start;
    logic [W-1:0]        a, n;
    logic                ready, busy, done;
    logic [W-1:0]        gcd_result;
    logic signed [W:0]   coeff_i;

    extended_gcd #(.WORD_WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .n          (n),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .gcd_result (gcd_result),
        .coeff_i    (coeff_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string  name;
        longint g;
        longint c;
        int     t;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference extended Euclid for generated vectors
    function automatic void model(input longint av, input longint nv,
                                  output longint g, output longint c, output int k);
        longint r0, r1, t0, t1, q, tmp;
        r0 = nv; r1 = av; t0 = 0; t1 = 1; k = 0;
        while (r1 != 0) begin
            q   = r0 / r1;
            tmp = r0 % r1;
            r0  = r1;
            r1  = tmp;
            tmp = t0 - q * t1;
            t0  = t1;
            t1  = tmp;
            k++;
        end
        g = r0;
        c = t0;
    endfunction

    // Monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && done) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
            end else begin
                e = sbq.pop_front();
                chk({e.name, ".gcd"},   longint'(gcd_result), e.g);
                chk({e.name, ".coeff"}, longint'(coeff_i),    e.c);
                chk({e.name, ".cycle"}, longint'(cyc),        longint'(e.t));
            end
        end
    end

    task automatic wait_ready(input string name);
        int w = 0;
        @(negedge clk);
        while (!ready && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (!ready) begin
            checks++;
            failures++;
            $display("FAIL %s.ready_timeout: got ready=0 expected ready=1", name);
        end
    endtask

    task automatic go(input string name, input logic [W-1:0] av, input logic [W-1:0] nv,
                      input longint g, input longint c, input int k, input bit repulse);
        int w = 0;
        wait_ready(name);
        a = av;
        n = nv;
        start = 1'b1;
        @(posedge clk);
        #1;
        // cyc now labels cycle 1 after the sampling edge
        sbq.push_back('{name, g, c, cyc + 2 + k * (W + 2) - 1});
        start = 1'b0;
        a = ~av;
        n = $urandom;
        chk({name, ".busy"},  longint'(busy),  1);
        chk({name, ".ready"}, longint'(ready), 0);
        if (repulse) begin
            repeat (5) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        while (sbq.size() != 0 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s.done_timeout: got no done expected done", name);
            sbq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        n = '0;
        repeat (3) @(negedge clk);
        chk("reset.ready", longint'(ready), 1);
        chk("reset.busy",  longint'(busy),  0);
        chk("reset.done",  longint'(done),  0);
        chk("reset.gcd",   longint'(gcd_result), 0);
        chk("reset.coeff", longint'(coeff_i),    0);
        rst = 1'b0;

        // Directed vectors (hand-computed)
        go("a3n7",      32'd3,  32'd7,    1,   -2, 2, 1'b0);
        go("a17n3120",  32'd17, 32'd3120, 1, -367, 4, 1'b1);
        go("a6n9",      32'd6,  32'd9,    3,   -1, 2, 1'b0);
        go("a0n11",     32'd0,  32'd11,  11,    0, 0, 1'b0);
        go("a5n0",      32'd5,  32'd0,    5,    1, 1, 1'b0);
        go("a0n0",      32'd0,  32'd0,    0,    0, 0, 1'b0);
        go("a10n4",     32'd10, 32'd4,    2,    1, 3, 1'b0);
        go("amax_nm1",  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1,  1, 3, 1'b0);
        go("am1_nmax",  32'hFFFF_FFFE, 32'hFFFF_FFFF, 1, -1, 2, 1'b0);

        // Abort: re-pulse mid-run, then reset at cycle 20
        begin
            wait_ready("abort");
            a = 32'd17;
            n = 32'd3120;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (5) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (14) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            chk("abort.ready", longint'(ready), 1);
            chk("abort.busy",  longint'(busy),  0);
            chk("abort.done",  longint'(done),  0);
            chk("abort.gcd",   longint'(gcd_result), 0);
            chk("abort.coeff", longint'(coeff_i),    0);
            rst = 1'b0;
            // Any late done pulse here is flagged by the monitor
            repeat (200) @(negedge clk);
            chk("abort.idle_ready", longint'(ready), 1);
        end
        go("after_abort", 32'd17, 32'd3120, 1, -367, 4, 1'b0);

        // Generated vectors against the reference model plus a Bezout check
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] av, nv;
            longint g, c;
            int k;
            longint unsigned cm, prod;
            av = $urandom;
            nv = (i < 2) ? W'($urandom_range(1, 1000)) : W'($urandom);
            model(longint'(av), longint'(nv), g, c, k);
            go($sformatf("rand%0d", i), av, nv, g, c, k, 1'b0);
            if (nv != 0) begin
                cm   = longint'(c) < 0 ? longint'(nv) - ((-c) % longint'(nv)) : c % longint'(nv);
                cm   = cm % nv;
                prod = (cm * (longint'(av) % longint'(nv))) % nv;
                chk($sformatf("rand%0d.bezout", i),
                    longint'((prod + nv - (longint'(gcd_result) % nv)) % nv), 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/extended_gcd.md
EXTENDED_GCD -- requirements
Module: extended_gcd

Interface
REQ-001 Parameter: WORD_WIDTH, default 32, operand width in bits.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request; sampled only while ready=1.
REQ-005 a  input  WORD_WIDTH  unsigned value to invert (e.g. public exponent).
REQ-006 n  input  WORD_WIDTH  unsigned modulus.
REQ-007 ready  output  1  high only in IDLE.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse when results become valid.
REQ-010 gcd_result  output  WORD_WIDTH  gcd(a,n).
REQ-011 coeff_i  output  signed WORD_WIDTH+1  Bezout coefficient t with t*a ≡ gcd_result (mod n); feeds the modular-inverse stage directly.

Function
REQ-012 Algorithm: iterative extended Euclid with r0=n, r1=a, t0=0, t1=1; while r1≠0: q=r0/r1, (r0,r1)←(r1, r0 mod r1), (t0,t1)←(t1, t0−q*t1); result gcd_result=r0, coeff_i=t0.
REQ-013 a and n are registered at the start handshake; later input changes have no effect on the running operation.
REQ-014 FSM states: IDLE, CHECK, DIVIDE, UPDATE, DONE.
REQ-015 IDLE→CHECK on start=1; start while busy=1 is ignored and not queued.
REQ-016 CHECK→DONE when r1=0, else CHECK→DIVIDE with one-cycle launch of the divider.
REQ-017 DIVIDE occupies exactly WORD_WIDTH cycles, then →UPDATE.
REQ-018 UPDATE registers the new r0, r1, t0, t1 in one cycle, then →CHECK.
REQ-019 DONE asserts done for exactly one cycle, then →IDLE unconditionally.
REQ-020 Latency (start-sampling edge to done-high cycle): 2 + k*(WORD_WIDTH+2) cycles, where k is the number of loop iterations.
REQ-021 q*t1 is formed at 2*WORD_WIDTH+2 signed bits; t0−q*t1 is truncated to WORD_WIDTH+1 bits, which is exact because |t| ≤ max(n,1).
REQ-022 gcd_result and coeff_i update only in DONE and hold their values until the next DONE or reset.
REQ-023 a=0: no iterations; result gcd=n, coeff=0.
REQ-024 n=0, a≠0: one iteration; result gcd=a, coeff=1.
REQ-025 a=n=0: result gcd=0, coeff=0; no division is ever issued with a zero divisor.
REQ-026 a>n: the first iteration has q=0 and swaps the operands; no special-casing.

Reset
REQ-027 rst=1 at any clock edge forces IDLE and clears ready to 1, busy 0, done 0, gcd_result 0, coeff_i 0, divider state 0.
REQ-028 Reset during any non-IDLE state aborts the operation; no done pulse is produced for the aborted request.

Structure
REQ-029 The shared package (rsa_pkg) holds the FSM state typedef egcd_state_t; WORD_WIDTH stays a module parameter.
REQ-030 The division is one sub-module, udiv_seq: restoring, one quotient bit per cycle, with start, dividend, divisor, quotient, remainder and valid ports.
REQ-031 The block contains no combinational divider or multi-cycle paths.

Verification
REQ-032 W=32, a=3, n=7 → done at cycle 70; gcd_result=1, coeff_i=−2 (inverse 5).
REQ-033 a=17, n=3120 → 4 iterations, done at cycle 138; gcd=1, coeff_i=−367 (inverse 2753).
REQ-034 a=6, n=9 → gcd=3, coeff_i=−1; downstream error path is exercised.
REQ-035 a=0, n=11 → done at cycle 2; gcd=11, coeff=0. a=5, n=0 → gcd=5, coeff=1.
REQ-036 start re-pulsed mid-run, then rst asserted at cycle 20 → the re-pulse is ignored; at reset all outputs are 0, ready=1 and no done pulse occurs; a new start then completes correctly.
REQ-037 Random a, n < 2^32 → self-check gcd and (coeff*a − gcd) mod n = 0 against a reference model.
